// File: rtl/axis_pkg.sv
// Shared AXI-Stream helpers: width math and beat packing for the loopback FIFO.
package axis_pkg;

    // Default tdata width; a stored beat is {tlast, tdata} with tlast at the MSB.
    localparam int c_AXIS_DEFAULT_WIDTH = 8;
    localparam int c_AXIS_BEAT_WIDTH    = c_AXIS_DEFAULT_WIDTH + 1;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    function automatic int beat_width(input int width);
        return width + 1;
    endfunction

    // Occupancy spans 0..depth inclusive, hence one bit more than the pointers.
    function automatic int level_width(input int depth);
        return clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/axis_fifo_ram.sv
// Simple dual-port storage for the loopback FIFO: synchronous write, asynchronous read.
module axis_fifo_ram
    import axis_pkg::*;
#(
    parameter int c_DEPTH      = 16,
    parameter int c_BEAT_WIDTH = c_AXIS_BEAT_WIDTH
) (
    input  logic                        clk,
    input  logic                        wr_en,
    input  logic [clog2(c_DEPTH)-1:0]   wr_addr,
    input  logic [c_BEAT_WIDTH-1:0]     wr_data,
    input  logic [clog2(c_DEPTH)-1:0]   rd_addr,
    output logic [c_BEAT_WIDTH-1:0]     rd_data
);

    logic [c_BEAT_WIDTH-1:0] mem [c_DEPTH];

    // NOTE: storage is deliberately not reset; the level counter decides which entries are valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/axis_loopback_fifo.sv
// AXI-Stream loopback through a first-word-fall-through FIFO with occupancy and packet counters.
// Define AXIS_LOOPBACK_PACKET_MODE_EN for store-and-forward output gating.
module axis_loopback_fifo
    import axis_pkg::*;
#(
    parameter int c_WIDTH     = 8,
    parameter int c_DEPTH     = 16,
    parameter int c_CNT_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic [c_WIDTH-1:0]          s_axis_tdata,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    input  logic                        s_axis_tlast,
    output logic [c_WIDTH-1:0]          m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        m_axis_tlast,
    output logic [clog2(c_DEPTH):0]     level,
    output logic [c_CNT_WIDTH-1:0]      pkt_count
);

    localparam int c_AW = clog2(c_DEPTH);
    localparam int c_LW = level_width(c_DEPTH);
    localparam int c_BW = beat_width(c_WIDTH);
    localparam logic [c_LW-1:0] c_FULL = c_LW'(c_DEPTH);

    logic [c_AW-1:0] wr_ptr;
    logic [c_AW-1:0] rd_ptr;
    logic [c_LW-1:0] level_next;
    logic [c_BW-1:0] wr_beat;
    logic [c_BW-1:0] rd_beat;
    logic            push;
    logic            pop;

    assign push    = s_axis_tvalid && s_axis_tready;
    assign pop     = m_axis_tvalid && m_axis_tready;
    assign wr_beat = {s_axis_tlast, s_axis_tdata};

    axis_fifo_ram #(
        .c_DEPTH      (c_DEPTH),
        .c_BEAT_WIDTH (c_BW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data (wr_beat),
        .rd_addr (rd_ptr),
        .rd_data (rd_beat)
    );

    assign m_axis_tdata = rd_beat[c_WIDTH-1:0];
    assign m_axis_tlast = rd_beat[c_WIDTH];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        level_next = level;
        if (push && !pop) begin
            level_next = level + 1'b1;
        end else if (pop && !push) begin
            level_next = level - 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            level         <= '0;
            s_axis_tready <= 1'b0;
            pkt_count     <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            level         <= level_next;
            // Ready is registered from the post-edge occupancy, never from m_axis_tready.
            s_axis_tready <= (level_next < c_FULL);
            if (pop && m_axis_tlast) begin
                pkt_count <= pkt_count + 1'b1;
            end
        end
    end

`ifdef AXIS_LOOPBACK_PACKET_MODE_EN
    logic [c_LW-1:0] pkts_stored;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pkts_stored <= '0;
        end else if ((push && s_axis_tlast) && !(pop && m_axis_tlast)) begin
            pkts_stored <= pkts_stored + 1'b1;
        end else if ((pop && m_axis_tlast) && !(push && s_axis_tlast)) begin
            pkts_stored <= pkts_stored - 1'b1;
        end
    end

    // A full FIFO releases data even without a complete packet so oversize packets cannot deadlock.
    always_comb begin
        m_axis_tvalid = (level != '0) && ((pkts_stored != '0) || (level == c_FULL));
    end
`else
    always_comb begin
        m_axis_tvalid = (level != '0);
    end
`endif

endmodule

// File: doc/axis_loopback_fifo.md
Name: axis_loopback_fifo

Overview:
Parametrised successor to the pass-through AXI-Stream loopback. It inserts a synchronous FIFO of c_DEPTH words between slave and master. This breaks the combinational tready/tvalid paths and absorbs downstream stalls. It also reports FIFO occupancy and counts completed output packets for test benches and debug.

Parameters:
c_WIDTH, 8, tdata width in bits (>=1)
c_DEPTH, 16, FIFO depth in words; power of two, >=2
c_CNT_WIDTH, 16, width of packet counter

Ports:
clk  input  1  system clock; all logic on rising edge
resetn  input  1  synchronous reset, active-low
s_axis_tdata  input  c_WIDTH  slave data
s_axis_tvalid  input  1  slave valid
s_axis_tready  output  1  slave ready (registered)
s_axis_tlast  input  1  slave end-of-packet
m_axis_tdata  output  c_WIDTH  master data
m_axis_tvalid  output  1  master valid
m_axis_tready  input  1  master ready
m_axis_tlast  output  1  master end-of-packet
level  output  clog2(c_DEPTH)+1  words currently stored
pkt_count  output  c_CNT_WIDTH  packets (tlast beats) sent on master side

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-low, resetn.
- Reset: while resetn==0 at a clk edge, the following are 0: level, pkt_count, read/write pointers, m_axis_tvalid, s_axis_tready. The value of m_axis_tdata/tlast is don't-care while tvalid==0. s_axis_tready rises on the first edge with resetn==1.
- Push: a beat is accepted when s_axis_tvalid && s_axis_tready at the edge. tdata and tlast are stored together (c_WIDTH+1 bits per entry).
- Pop: a beat is consumed when m_axis_tvalid && m_axis_tready at the edge.
- s_axis_tready is a register. Its next value is (level_next < c_DEPTH). It never depends combinationally on m_axis_tready.
- m_axis_tvalid = (level != 0), or the gated form under the optional feature. Output is first-word-fall-through.
- Latency: a beat accepted into an empty FIFO at edge N appears on the master side in the cycle after edge N. There is no same-cycle bypass.
- Simultaneous push and pop: level is unchanged and both pointers advance. This is legal at any level where both handshakes occur.
- Full (level==c_DEPTH): s_axis_tready=0. A pop at this edge sets level=c_DEPTH-1 and tready=1 from the next cycle. There is no pass-through while full.
- Empty: m_axis_tvalid=0. m_axis_tready is ignored.
- Pointers: clog2(c_DEPTH) bits each and wrap modulo c_DEPTH. level is tracked as a separate counter with range 0..c_DEPTH.
- pkt_count: increments on every pop with m_axis_tlast=1. It wraps modulo 2^c_CNT_WIDTH with no saturation.
- AXIS stability: once m_axis_tvalid=1, tdata, tlast and tvalid stay constant until the handshake completes.
- Reset mid-packet: all stored data is discarded. pkt_count is not incremented for partial packets. Upstream must restart the packet.

Optional Feature:
Macro AXIS_LOOPBACK_PACKET_MODE_EN.
- Defined (store-and-forward): an extra counter pkts_stored counts stored tlast beats. It increments on push with tlast and decrements on pop with tlast; both at once leaves it unchanged. m_axis_tvalid = (level!=0) && (pkts_stored!=0 || level==c_DEPTH). The full-FIFO override forces cut-through for packets longer than c_DEPTH, which prevents deadlock.
- Undefined: cut-through as above; no pkts_stored logic is synthesised.

Decomposition:
- Shared package axis_pkg holds:
  - clog2 constant function
  - AXIS beat width constant (c_WIDTH+1, tlast packed at the MSB)
  - level-width helper
- One sub-module, axis_fifo_ram: simple dual-port RAM with one write port and one asynchronous-read port, c_DEPTH x (c_WIDTH+1), on clk.
- Control (pointers, level, ready/valid, counters) stays in axis_loopback_fifo.

Test Plan:
1. Reset and idle:
   - Stimulus: resetn=0 for 3 cycles, then 1.
   - Response: s_axis_tready=0, m_axis_tvalid=0, level=0 during reset; tready=1 one edge after release.
2. Single beat:
   - Stimulus: push 0xA5 with tlast=1 into empty FIFO at edge N, m_axis_tready=1.
   - Response: m_axis_tvalid=1 with tdata=0xA5, tlast=1 in the cycle after N; pkt_count=1 after the pop.
3. Fill and backpressure:
   - Stimulus: m_axis_tready=0, push 0..15 (c_DEPTH=16).
   - Response: level=16 and s_axis_tready=0; the 17th beat is held. Releasing tready outputs 0..15 in order, then beat 16.
4. Streaming:
   - Stimulus: both ready/valid held high, 1000 random beats.
   - Response: output sequence equals input sequence; level stays at 1 steady-state; no bubbles after the first beat.
5. Wrap and count:
   - Stimulus: c_CNT_WIDTH=4, 17 single-beat packets.
   - Response: pkt_count=1.
6. Packet mode (AXIS_LOOPBACK_PACKET_MODE_EN):
   - Stimulus: push 4-beat packet with m_axis_tready=1.
   - Response: m_axis_tvalid stays 0 until the edge after the tlast beat is accepted.
   - Stimulus: push a 20-beat packet with c_DEPTH=16.
   - Response: output starts when level=16; all 20 beats delivered.
